// File: rtl/chirp_ramp_gen.sv
// chirp_ramp_gen: FMCW sawtooth ramp word source for the SPI DAC driver.
// Emits {CMD, code} frames from start up to stop in step increments. Between
// chirps it holds the start code for HOLD_WORDS words. It advances one word per
// driver load pulse and pulses chirp-sync on the first word of every chirp.
module chirp_ramp_gen #(
    parameter logic [7:0] CMD        = 8'h00,
    parameter int         HOLD_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_run,
    input  logic [15:0] i_f_start,
    input  logic [15:0] i_f_stop,
    input  logic [15:0] i_step,
    input  logic [7:0]  i_n_chirps,
    input  logic        i_load_data,
    input  logic        i_dac_busy,
    output logic        o_dac_start,
    output logic [23:0] o_dac_data,
    output logic        o_chirp_sync,
    output logic        o_active,
    output logic        o_cfg_err,
    output logic [7:0]  o_chirp_cnt
);

    typedef enum logic [1:0] {IDLE, RAMP, HOLD, DRAIN} state_t;

    // The last hold word doubles as the next chirp's first word, so counting
    // starts one below the retrace length.
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_WORDS - 1);

    state_t      state, state_nxt;
    logic [15:0] code, code_nxt;
    logic [15:0] hold_cnt, hold_nxt;
    logic [15:0] start_r, stop_r, step_r;
    logic [7:0]  n_r;
    logic [7:0]  cnt, cnt_nxt;
    logic        first, first_nxt;
    logic        start_nxt, sync_nxt, err_nxt;
    logic        run_q, arm, cfg_bad;
    logic        chirp_end, done;
    logic [16:0] sum;

    assign arm     = i_run & ~run_q;
    assign cfg_bad = (i_step == 16'd0) || (i_f_stop < i_f_start);

    // i_run edge detector; it comes out of reset "high" so a level already
    // asserted at reset release has to be toggled before it arms.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) run_q <= 1'b1;
        else     run_q <= i_run;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and datapath decisions; one shared 17-bit adder serves both
    // RAMP (code+step) and the final HOLD word (code is start there).
    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        hold_nxt  = hold_cnt;
        cnt_nxt   = cnt;
        first_nxt = first;
        start_nxt = o_dac_start;
        sync_nxt  = 1'b0;
        err_nxt   = 1'b0;
        chirp_end = 1'b0;
        done      = 1'b0;
        sum       = {1'b0, code} + {1'b0, step_r};
        unique case (state)
            IDLE: begin
                if (arm) begin
                    if (cfg_bad) begin
                        err_nxt = 1'b1;
                    end else begin
                        state_nxt = RAMP;
                        code_nxt  = i_f_start;
                        cnt_nxt   = 8'd0;
                        first_nxt = 1'b1;
                        start_nxt = 1'b1;
                    end
                end
            end
            RAMP, HOLD: begin
                if (i_load_data) begin
                    if (state == HOLD && hold_cnt != 16'd0) begin
                        hold_nxt = hold_cnt - 16'd1;
                    end else begin
                        sync_nxt  = (state == HOLD) || first;
                        first_nxt = 1'b0;
                        if (sum > {1'b0, stop_r}) begin
                            chirp_end = 1'b1;
                            cnt_nxt   = cnt + 8'd1;
                            code_nxt  = start_r;
                            hold_nxt  = HOLD_LAST;
                            state_nxt = HOLD;
                        end else begin
                            code_nxt  = sum[15:0];
                            state_nxt = RAMP;
                        end
                    end
                    done = chirp_end && (n_r != 8'd0) && (cnt_nxt == n_r);
                    if (done || !i_run) begin
                        state_nxt = DRAIN;
                        start_nxt = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (!i_dac_busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers, registered pulses and the config snapshot taken at arm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code         <= 16'd0;
            hold_cnt     <= 16'd0;
            cnt          <= 8'd0;
            first        <= 1'b0;
            o_dac_start  <= 1'b0;
            o_chirp_sync <= 1'b0;
            o_cfg_err    <= 1'b0;
            start_r      <= 16'd0;
            stop_r       <= 16'd0;
            step_r       <= 16'd0;
            n_r          <= 8'd0;
        end else begin
            code         <= code_nxt;
            hold_cnt     <= hold_nxt;
            cnt          <= cnt_nxt;
            first        <= first_nxt;
            o_dac_start  <= start_nxt;
            o_chirp_sync <= sync_nxt;
            o_cfg_err    <= err_nxt;
            if (state == IDLE && arm && !cfg_bad) begin
                start_r <= i_f_start;
                stop_r  <= i_f_stop;
                step_r  <= i_step;
                n_r     <= i_n_chirps;
            end
        end
    end

    // Outputs derived from state and registers.
    always_comb begin
        o_active    = (state != IDLE);
        o_dac_data  = {CMD, code};
        o_chirp_cnt = cnt;
    end

endmodule

// File: tb/tb_chirp_ramp_gen.sv
// Self-checking bench for chirp_ramp_gen: a driver model pulses loads at random
// gaps, and every captured frame is compared against an expected word list
// built directly from the ramp/retrace rules.
module tb_chirp_ramp_gen;

    localparam logic [7:0] CMD        = 8'h00;
    localparam int         HOLD_WORDS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [15:0] f_start, f_stop, step;
    logic [7:0]  n_chirps;
    logic        load, busy;
    logic        dac_start;
    logic [23:0] dac_data;
    logic        chirp_sync, active, cfg_err;
    logic [7:0]  chirp_cnt;

    typedef struct {
        int code;
        bit sync;
        bit endc;
    } exp_t;

    exp_t expQ[$];
    int   testCount = 0;
    int   failCount = 0;

    always #5 clk = ~clk;

    chirp_ramp_gen #(.CMD(CMD), .HOLD_WORDS(HOLD_WORDS)) dut (
        .clk(clk), .rst(rst), .i_run(run),
        .i_f_start(f_start), .i_f_stop(f_stop), .i_step(step), .i_n_chirps(n_chirps),
        .i_load_data(load), .i_dac_busy(busy),
        .o_dac_start(dac_start), .o_dac_data(dac_data), .o_chirp_sync(chirp_sync),
        .o_active(active), .o_cfg_err(cfg_err), .o_chirp_cnt(chirp_cnt)
    );

    // Hard stop so a hung DUT can never keep the bench alive.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Expected captured words: chirp 1 is the plain ramp; every later chirp is
    // preceded by HOLD_WORDS-1 pure retrace words, and its start word is the
    // final retrace word.
    task automatic buildModel(input int s, input int e, input int st, input int n, input int maxLoads);
        int chirp;
        expQ.delete();
        chirp = 0;
        while (expQ.size() < maxLoads && (n == 0 || chirp < n)) begin
            if (chirp > 0)
                for (int h = 0; h < HOLD_WORDS - 1; h++)
                    expQ.push_back('{code: s, sync: 1'b0, endc: 1'b0});
            for (int w = s; w <= e && expQ.size() < maxLoads; w += st)
                expQ.push_back('{code: w, sync: (w == s), endc: (w + st > e)});
            chirp++;
        end
    endtask

    // dropAt: -1 never drop run, -2 drop at a random load, else drop at that load.
    task automatic applyStimulus(input int s, input int e, input int st, input int n,
                                 input int dropAt, input int maxLoads);
        int lastIdx, dropIdx, expCnt, gap, lim;
        buildModel(s, e, st, n, maxLoads);
        lim = (expQ.size() < 60) ? expQ.size() : 60;
        dropIdx = (dropAt == -2) ? int'($urandom_range(0, lim - 1)) : dropAt;
        lastIdx = (dropIdx >= 0) ? dropIdx : expQ.size() - 1;

        @(negedge clk);
        f_start = s[15:0]; f_stop = e[15:0]; step = st[15:0]; n_chirps = n[7:0];
        run = 1'b0; load = 1'b0; busy = 1'b0;
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        checkOutput("arm_start", dac_start, 1);
        checkOutput("arm_active", active, 1);
        checkOutput("arm_data", dac_data, {CMD, s[15:0]});
        checkOutput("arm_cnt", chirp_cnt, 0);
        busy = 1'b1;
        f_start = 16'($urandom); f_stop = 16'($urandom);
        step = 16'($urandom); n_chirps = 8'($urandom);
        expCnt = 0;

        for (int i = 0; i <= lastIdx; i++) begin
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin
                @(negedge clk);
                checkOutput("gap_data", dac_data, {CMD, expQ[i].code[15:0]});
                checkOutput("gap_sync", chirp_sync, 0);
            end
            @(negedge clk);
            checkOutput("load_data", dac_data, {CMD, expQ[i].code[15:0]});
            checkOutput("pre_sync", chirp_sync, 0);
            if (i == dropIdx) run = 1'b0;
            load = 1'b1;
            @(negedge clk);
            load = 1'b0;
            if (expQ[i].endc) expCnt = (expCnt + 1) % 256;
            checkOutput("sync", chirp_sync, 32'(expQ[i].sync));
            checkOutput("cnt", chirp_cnt, 32'(expCnt));
            checkOutput("dac_start", dac_start, (i == lastIdx) ? 0 : 1);
            checkOutput("active", active, 1);
        end

        repeat (2) begin
            @(negedge clk);
            checkOutput("drain_active", active, 1);
            checkOutput("drain_start", dac_start, 0);
        end
        busy = 1'b0;
        @(negedge clk);
        checkOutput("idle_active", active, 0);
        checkOutput("idle_cnt", chirp_cnt, 32'(expCnt));
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        checkOutput("idle_load_start", dac_start, 0);
        checkOutput("idle_load_sync", chirp_sync, 0);
        checkOutput("idle_norearm", active, 0);
        run = 1'b0;
    endtask

    task automatic cfgErrorTest(input int s, input int e, input int st);
        @(negedge clk);
        f_start = s[15:0]; f_stop = e[15:0]; step = st[15:0]; n_chirps = 8'd1;
        run = 1'b0;
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        checkOutput("cfg_err_pulse", cfg_err, 1);
        checkOutput("cfg_err_start", dac_start, 0);
        checkOutput("cfg_err_active", active, 0);
        @(negedge clk);
        checkOutput("cfg_err_clear", cfg_err, 0);
        checkOutput("cfg_err_idle", active, 0);
        run = 1'b0;
    endtask

    task automatic resetTest();
        @(negedge clk);
        f_start = 16'd100; f_stop = 16'd130; step = 16'd10; n_chirps = 8'd0;
        run = 1'b0; busy = 1'b1;
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checkOutput("rst_pre_active", active, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_async_start", dac_start, 0);
        checkOutput("rst_async_active", active, 0);
        checkOutput("rst_async_data", dac_data, 0);
        checkOutput("rst_async_sync", chirp_sync, 0);
        @(negedge clk);
        rst = 1'b0;
        busy = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_run_high_noarm", active, 0);
        checkOutput("rst_run_high_start", dac_start, 0);
        run = 1'b0;
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        checkOutput("rst_rearm_start", dac_start, 1);
        checkOutput("rst_rearm_data", dac_data, {CMD, 16'd100});
        run = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checkOutput("rst_stop_start", dac_start, 0);
        repeat (2) @(negedge clk);
        checkOutput("rst_final_idle", active, 0);
    endtask

    initial begin
        int rs, rr, rst_n, rn;
        rst = 1'b1; run = 1'b1; load = 1'b0; busy = 1'b0;
        f_start = '0; f_stop = '0; step = '0; n_chirps = '0;
        #12;
        checkOutput("reset_start", dac_start, 0);
        checkOutput("reset_data", dac_data, 0);
        checkOutput("reset_sync", chirp_sync, 0);
        checkOutput("reset_active", active, 0);
        checkOutput("reset_err", cfg_err, 0);
        checkOutput("reset_cnt", chirp_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("release_run_high", active, 0);
        run = 1'b0;

        applyStimulus(100, 130, 10, 1, -1, 400);
        applyStimulus(0, 25, 10, 2, -1, 400);
        cfgErrorTest(5, 10, 0);
        cfgErrorTest(200, 100, 5);
        applyStimulus(100, 300, 7, 0, 12, 400);
        applyStimulus(16'hFFFF, 16'hFFFF, 1, 3, -1, 400);
        applyStimulus(50, 50, 3, 0, 515, 540);

        for (int k = 0; k < 8; k++) begin
            rr = int'($urandom_range(0, 80));
            rs = int'($urandom_range(0, 65535 - rr));
            rst_n = int'($urandom_range(1, 40));
            rn = int'($urandom_range(0, 3));
            applyStimulus(rs, rs + rr, rst_n, rn, ($urandom_range(0, 1) == 1 || rn == 0) ? -2 : -1, 400);
        end

        resetTest();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
